// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a 3-sample mid-bit majority vote,
// optional even/odd parity and registered one-cycle result flags.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  busy
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [EW-1:0] EDGE_ONE  = EW'(1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] SAMPLE_A  = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] SAMPLE_B  = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] SAMPLE_C  = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, next_state;
  logic                  rx_meta, rx_s;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  samp_a, samp_b, samp_c;
  logic                  maj;
  logic                  bit_done;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_en_q, par_typ_q, par_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  assign maj      = (samp_a & samp_b) | (samp_a & samp_c) | (samp_b & samp_c);
  assign bit_done = (edge_cnt == EDGE_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!rx_s) next_state = START;
      START:   if (bit_done) next_state = maj ? IDLE : DATA;
      DATA:    if (bit_done && bit_cnt == BIT_LAST) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) next_state = STOP;
      STOP:    if (bit_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The start-detect cycle counts as edge 0, so the counter enters START at 1.
  // OVERSAMPLE is a power of two, so the counter wraps by itself at bit end.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      samp_c     <= 1'b1;
      data_reg   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err_q  <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (edge_cnt == SAMPLE_A) samp_a <= rx_s;
      if (edge_cnt == SAMPLE_B) samp_b <= rx_s;
      if (edge_cnt == SAMPLE_C) samp_c <= rx_s;
      if (state == IDLE) edge_cnt <= rx_s ? '0 : EDGE_ONE;
      else               edge_cnt <= edge_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_err_q <= 1'b0;
            bit_cnt   <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            data_reg[bit_cnt] <= maj;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_done) par_err_q <= (maj != (par_typ_q ? ~^data_reg : ^data_reg));
        end
        STOP: begin
          if (bit_done) begin
            STP_ERR <= ~maj;
            PAR_ERR <= par_err_q;
            if (maj && !par_err_q) begin
              Data_Valid <= 1'b1;
              P_DATA     <= data_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed UART frames checked against a frame-level
// model predicting each result pulse, its cycle, and the held P_DATA value.
module tb_uart_rx;

  localparam int OS = 8;

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
    int         cyc;
  } evt_t;

  logic       CLK_tb;
  logic       rst_n;
  logic       rx_in;
  logic       par_en_tb;
  logic       par_typ_tb;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, busy;

  int   cyc = 0;
  int   busy_total = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] exp_pdata = 8'h00;
  evt_t obs_q[$];
  evt_t exp_q[$];

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
    .CLK        (CLK_tb),
    .RST        (rst_n),
    .RX_IN      (rx_in),
    .PAR_EN     (par_en_tb),
    .PAR_TYP    (par_typ_tb),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .PAR_ERR    (par_err),
    .STP_ERR    (stp_err),
    .busy       (busy)
  );

  initial CLK_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  always @(posedge CLK_tb) cyc <= cyc + 1;

  // Every result pulse is logged with its cycle stamp and the P_DATA seen with it.
  always @(negedge CLK_tb) begin
    evt_t e;
    if (busy) busy_total <= busy_total + 1;
    if (data_valid || par_err || stp_err) begin
      e.dv = data_valid;
      e.pe = par_err;
      e.se = stp_err;
      e.data = p_data;
      e.cyc = cyc;
      obs_q.push_back(e);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_tb);
      #1 rx_in = 1'b1;
    end
  endtask

  // Drives one frame, one line value per clock, and predicts its outcome.
  task automatic applyStimulus(input logic [7:0] data, input bit pen, input bit ptyp,
                               input bit pflip, input bit stop_val,
                               input int glitch_bit, input int abort_bit);
    logic [10:0] bits;
    int          nbits;
    int          start_cyc;
    logic        par_bit;
    bit          par_bad, stop_bad;
    evt_t        e;
    par_bit = (^data) ^ ptyp ^ pflip;
    nbits = pen ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) bits[1+j] = data[j];
    if (pen) bits[9] = par_bit;
    bits[nbits-1] = stop_val;
    start_cyc = 0;
    for (int i = 0; i < nbits; i++) begin
      for (int k = 0; k < OS; k++) begin
        @(posedge CLK_tb);
        #1;
        if (i == 0 && k == 0) begin
          start_cyc = cyc;
          par_en_tb = pen;
          par_typ_tb = ptyp;
        end
        if (i == 3 && k == 0) begin
          par_en_tb = 1'($urandom_range(1));
          par_typ_tb = 1'($urandom_range(1));
        end
        if (i == abort_bit && k == OS / 2) begin
          rst_n = 1'b0;
          repeat (2) @(posedge CLK_tb);
          #1;
          checkOutput("abort_reset_outputs", {20'd0, p_data, data_valid, par_err, stp_err, busy}, 32'd0);
          rx_in = 1'b1;
          rst_n = 1'b1;
          exp_pdata = 8'h00;
          return;
        end
        rx_in = (i == glitch_bit && k == OS / 2) ? ~bits[i] : bits[i];
      end
    end
    par_bad = pen && (par_bit != ((^data) ^ ptyp));
    stop_bad = !stop_val;
    e.dv = !par_bad && !stop_bad;
    if (e.dv) exp_pdata = data;
    e.pe = par_bad;
    e.se = stop_bad;
    e.data = exp_pdata;
    e.cyc = start_cyc + 2 + nbits * OS;
    exp_q.push_back(e);
  endtask

  task automatic verifyEvents(input string tag);
    int n;
    checkOutput({tag, "_event_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_evt%0d_flags", tag, i),
                  {29'd0, obs_q[i].dv, obs_q[i].pe, obs_q[i].se},
                  {29'd0, exp_q[i].dv, exp_q[i].pe, exp_q[i].se});
      checkOutput($sformatf("%s_evt%0d_cycle", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      checkOutput($sformatf("%s_evt%0d_p_data", tag, i), {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int b0;
    int nb, gb;
    rst_n = 1'b0;
    rx_in = 1'b1;
    par_en_tb = 1'b0;
    par_typ_tb = 1'b0;
    repeat (3) @(posedge CLK_tb);
    #1;
    checkOutput("reset_outputs", {20'd0, p_data, data_valid, par_err, stp_err, busy}, 32'd0);
    rst_n = 1'b1;
    applyIdle(5);

    $display("[TB] 0xDB even parity");
    b0 = busy_total;
    applyStimulus(8'hDB, 1, 0, 0, 1, -1, -1);
    applyIdle(OS + 4);
    checkOutput("db_busy_cycles", busy_total - b0, 11 * OS - 1);
    checkOutput("db_p_data", {24'd0, p_data}, {24'd0, exp_pdata});
    verifyEvents("db");

    $display("[TB] 0xAA odd parity then 0xDB no parity, back-to-back");
    applyStimulus(8'hAA, 1, 1, 0, 1, -1, -1);
    applyStimulus(8'hDB, 0, 0, 0, 1, -1, -1);
    applyIdle(OS + 4);
    verifyEvents("b2b");

    $display("[TB] 0x55 with bad parity bit");
    applyStimulus(8'h55, 1, 0, 1, 1, -1, -1);
    applyIdle(OS + 4);
    checkOutput("par_err_p_data_hold", {24'd0, p_data}, 32'hDB);
    verifyEvents("par");

    $display("[TB] 0x3C with stop bit low");
    applyStimulus(8'h3C, 0, 0, 0, 0, -1, -1);
    applyIdle(OS + 4);
    verifyEvents("stp");

    $display("[TB] start glitch, then mid-bit glitch inside a frame");
    b0 = busy_total;
    @(posedge CLK_tb);
    #1 rx_in = 1'b0;
    @(posedge CLK_tb);
    #1 rx_in = 1'b0;
    applyIdle(3 * OS);
    checkOutput("glitch_busy_cycles", busy_total - b0, OS - 1);
    applyStimulus(8'hA5, 0, 0, 0, 1, 3, -1);
    applyIdle(OS + 4);
    verifyEvents("glitch");

    $display("[TB] reset during data bit 4, then 0x81");
    applyStimulus(8'hC3, 0, 0, 0, 1, -1, 5);
    applyIdle(4);
    checkOutput("after_abort_p_data", {24'd0, p_data}, {24'd0, exp_pdata});
    applyStimulus(8'h81, 0, 0, 0, 1, -1, -1);
    applyIdle(OS + 4);
    verifyEvents("abort");

    $display("[TB] random frames");
    for (int f = 0; f < 40; f++) begin
      logic [7:0] d;
      bit pen, ptyp, pflip, stopv;
      d = 8'($urandom);
      pen = 1'($urandom_range(1));
      ptyp = 1'($urandom_range(1));
      pflip = ($urandom_range(4) == 0);
      stopv = ($urandom_range(5) != 0);
      nb = pen ? 11 : 10;
      gb = ($urandom_range(2) == 0) ? int'($urandom_range(nb - 1)) : -1;
      applyStimulus(d, pen, ptyp, pflip, stopv, gb, -1);
      applyIdle(($urandom_range(2) == 0) ? 0 : int'($urandom_range(2 * OS, 1)));
    end
    applyIdle(OS + 4);
    verifyEvents("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver. It is the downstream stage of the team's UART transmitter and consumes the transmitter's serial line.
- Recovers frames of the form: start(0), 8 data bits LSB-first, optional parity bit, stop(1).
- Presents the recovered byte as a one-cycle Data_Valid pulse, with parity and stop-bit error flags.
- Oversamples the line at OVERSAMPLE clocks per bit and uses a 3-sample majority vote at mid-bit.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 8, clock cycles per serial bit. Legal values: 8, 16, 32.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line. Idle high. Asynchronous to CLK.
- PAR_EN  input  1  1 means a parity bit is present in the frame.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last received byte. Holds its value until the next good frame.
- Data_Valid  output  1  one-cycle pulse. P_DATA is new and error-free.
- PAR_ERR  output  1  one-cycle pulse. Parity mismatch on the current frame.
- STP_ERR  output  1  one-cycle pulse. Stop bit sampled as 0.
- busy  output  1  high from start-bit detection until the frame is resolved.

Behaviour:
- Reset (RST=0, asynchronous):
  - State = IDLE. All counters = 0.
  - P_DATA = 0. Data_Valid, PAR_ERR, STP_ERR and busy = 0.
  - Both synchronizer flops reset to 1.
  - Reset asserted mid-frame abandons the frame. No flags fire.
- Input synchronizer:
  - RX_IN passes through a 2-flop synchronizer. All timing below refers to the synchronized signal rx_s, which lags RX_IN by 2 cycles.
- Counters:
  - edge_cnt counts 0..OVERSAMPLE-1 within a bit, then wraps to 0.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Majority sampling:
  - Take three samples of rx_s at edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - Bit value = majority of the three. It is valid from edge_cnt = OVERSAMPLE/2+2.
- States:
  - IDLE:
    - busy=0.
    - When rx_s=0: go to START. This cycle is edge_cnt=0.
    - Latch PAR_EN and PAR_TYP. Mid-frame changes to these inputs are ignored.
  - START:
    - At edge_cnt=OVERSAMPLE-1: if the majority bit is 1 (glitch), return to IDLE silently. Otherwise go to DATA.
  - DATA:
    - At edge_cnt=OVERSAMPLE-1: shift the majority bit into the shift register at position bit_cnt (LSB first).
    - After bit DATA_WIDTH-1: go to PARITY if the latched PAR_EN=1, else go to STOP.
  - PARITY:
    - At edge_cnt=OVERSAMPLE-1: compute expected = ^data for even parity, ~^data for odd parity.
    - Store mismatch = (majority bit != expected).
    - Go to STOP.
  - STOP, at edge_cnt=OVERSAMPLE-1, with the outcome registered so the flags appear on the next cycle:
    - Stop bit = 0: STP_ERR=1.
    - Parity mismatch stored: PAR_ERR=1.
    - Neither error: Data_Valid=1 and P_DATA updated in that same cycle.
    - Any error: no Data_Valid and P_DATA is unchanged. Both error flags can fire together.
    - Return to IDLE.
- busy:
  - Drops in the same cycle that the flags or Data_Valid are asserted.
- Back-to-back frames:
  - A start bit immediately after the stop bit is detected with no lost cycles.
  - IDLE sees rx_s=0 on the cycle after STOP completes.
- Latency:
  - Measured from the RX_IN falling edge of the start bit to Data_Valid.
  - 2 + N*OVERSAMPLE cycles, where N = 10 without parity and 11 with parity.
  - OVERSAMPLE=8, no parity: 82 cycles.
- Line stuck low after a stop error:
  - The frame is reported as a stop error, then IDLE immediately re-enters START.

Test Plan:
- Serial frame for 0xDB, PAR_EN=1, even parity (parity bit 0), OVERSAMPLE=8 -> Data_Valid pulses once, 90 cycles after the start edge. P_DATA=0xDB. PAR_ERR=0, STP_ERR=0. busy high throughout the frame.
- 0xAA, PAR_EN=1, odd parity (parity bit 1), then 0xDB with PAR_EN=0, sent back-to-back with no idle gap -> two Data_Valid pulses, with P_DATA=0xAA then 0xDB. No errors.
- 0x55, even parity, with the parity bit forced to 1 -> PAR_ERR pulses one cycle. No Data_Valid. P_DATA keeps its previous value.
- 0x3C, no parity, with the stop bit driven 0 -> STP_ERR pulses one cycle. No Data_Valid.
- RX_IN low for 2 clocks, then high -> no state change beyond START, no flags, busy drops within OVERSAMPLE cycles. A 1-clock glitch inside a data bit at sample point OVERSAMPLE/2 is outvoted, and the byte is received correctly.
- RST asserted during data bit 4, released, then a clean frame 0x81 sent -> no flags from the aborted frame. All outputs are 0 during reset. 0x81 is received correctly.
